// File: rtl/sobel_pkg.sv
// Shared constants, width helpers and sync payload type for the Sobel edge detector.
package sobel_pkg;

  localparam int unsigned LAT = 5;

  localparam logic MAG_SUM    = 1'b0;
  localparam logic MAG_MAXMIN = 1'b1;
  localparam logic OUT_BIN    = 1'b0;
  localparam logic OUT_MAG    = 1'b1;

  // Width of the unsigned partial sums p + 2q + r.
  function automatic int unsigned SUM_W(input int unsigned data_w);
    return data_w + 2;
  endfunction

  // Width of the gradient magnitude; wide enough for |Gx|+|Gy| without overflow.
  function automatic int unsigned MAG_W(input int unsigned data_w);
    return data_w + 3;
  endfunction

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } sync_t;

endpackage

// File: rtl/sobel_edge_param_if.sv
// Video in/out bundle: the source side drives in_*, the filter drives out_*.
interface sobel_edge_param_if #(
  parameter int unsigned DATA_W = 8
);

  logic              in_vs;
  logic              in_hs;
  logic              in_de;
  logic [DATA_W-1:0] in_y;
  logic              out_vs;
  logic              out_hs;
  logic              out_de;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_vs, in_hs, in_de, in_y,
    input  out_vs, out_hs, out_de, out_data
  );

  modport slave (
    input  in_vs, in_hs, in_de, in_y,
    output out_vs, out_hs, out_de, out_data
  );

endinterface

// File: rtl/sobel_line_buf.sv
// Two-line window buffer: mem1 holds the previous line, mem0 the line before it.
// mem0 is refilled from mem1's read data one cycle later, so one address serves both.
module sobel_line_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 1280,
  localparam int unsigned AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] row0,
  output logic [DATA_W-1:0] row1
);

  logic [DATA_W-1:0] mem0 [IMG_W];
  logic [DATA_W-1:0] mem1 [IMG_W];
  logic              casc_en;
  logic [AW-1:0]     casc_addr;

  // RAM write ports: current pixel into mem1, displaced previous-line pixel into mem0
  always_ff @(posedge clk) begin
    if (wr_en) mem1[addr] <= wr_data;
    if (casc_en) mem0[casc_addr] <= row1;
  end

  // Synchronous reads (read-before-write) and the delayed cascade control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row0      <= '0;
      row1      <= '0;
      casc_en   <= 1'b0;
      casc_addr <= '0;
    end else begin
      row0      <= mem0[addr];
      row1      <= mem1[addr];
      casc_en   <= wr_en;
      casc_addr <= addr;
    end
  end

endmodule

// File: rtl/sobel_edge_param.sv
// Streaming 3x3 Sobel edge detector on luma: binary edge map or saturated magnitude,
// five-stage pipeline with matching sync delay, border masking and line overflow guard.
module sobel_edge_param
  import sobel_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 1280
) (
  input  logic              clk,
  input  logic              rst_n,
  sobel_edge_param_if.slave vid,
  input  logic [DATA_W+2:0] threshold,
  input  logic              mag_mode,
  input  logic              out_sel,
  output logic              line_ovf
);

  localparam int unsigned SW   = SUM_W(DATA_W);
  localparam int unsigned MW   = MAG_W(DATA_W);
  localparam int unsigned AW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned CW   = $clog2(IMG_W + 1);
  localparam int unsigned RW   = 16;
  localparam int unsigned LAST = LAT - 2;

  localparam logic [CW-1:0]     COL_MAX = CW'(IMG_W);
  localparam logic [CW-1:0]     COL_MIN = CW'(2);
  localparam logic [RW-1:0]     ROW_MIN = RW'(2);
  localparam logic [MW-1:0]     SAT     = MW'({DATA_W{1'b1}});

  logic              vs_d, de_d, frame_act;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [MW-1:0]     threshold_f;
  logic              mag_mode_f, out_sel_f;

  logic              vs_rise, de_fall, pix_ovf, border, wr_en;
  logic [AW-1:0]     addr;

  logic [DATA_W-1:0] row0, row1, y1;
  logic [DATA_W-1:0] w1_0, w1_1, w1_2, w2_0, w2_1, w2_2;
  logic [SW-1:0]     gx_p, gx_n, gy_p, gy_n, ax, ay, mx, mn;
  logic [MW-1:0]     m;
  sync_t             sync_q [LAT-1];
  logic              bg_q   [LAT-1];

  // Edge detects, border / overflow decode and line-buffer addressing for the incoming pixel
  always_comb begin
    vs_rise = vid.in_vs & ~vs_d;
    de_fall = ~vid.in_de & de_d;
    pix_ovf = (col == COL_MAX);
    border  = (row < ROW_MIN) || (col < COL_MIN) || pix_ovf;
    wr_en   = vid.in_de & ~pix_ovf;
    addr    = pix_ovf ? '0 : AW'(col);
  end

  // Frame-level state: sync history, per-frame configuration, sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d        <= 1'b0;
      de_d        <= 1'b0;
      frame_act   <= 1'b0;
      threshold_f <= '0;
      mag_mode_f  <= 1'b0;
      out_sel_f   <= 1'b0;
      line_ovf    <= 1'b0;
    end else begin
      vs_d <= vid.in_vs;
      de_d <= vid.in_de;
      if (vs_rise) begin
        frame_act   <= 1'b1;
        threshold_f <= threshold;
        mag_mode_f  <= mag_mode;
        out_sel_f   <= out_sel;
        line_ovf    <= 1'b0;
      end else if (vid.in_de && pix_ovf) begin
        line_ovf <= 1'b1;
      end
    end
  end

  // Pixel column (saturating at IMG_W) and line counters; row only advances inside a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else begin
      if (vid.in_de) begin
        if (!pix_ovf) col <= col + CW'(1);
      end else if (de_fall) begin
        col <= '0;
      end
      if (vs_rise) begin
        row <= '0;
      end else if (de_fall && frame_act && (row != '1)) begin
        row <= row + RW'(1);
      end
    end
  end

  sobel_line_buf #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .addr    (addr),
    .wr_data (vid.in_y),
    .row0    (row0),
    .row1    (row1)
  );

  // S1: current pixel beside the line-buffer read; two older columns shifted behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1   <= '0;
      w1_0 <= '0;
      w1_1 <= '0;
      w1_2 <= '0;
      w2_0 <= '0;
      w2_1 <= '0;
      w2_2 <= '0;
    end else begin
      y1   <= vid.in_y;
      w1_0 <= row0;
      w1_1 <= row1;
      w1_2 <= y1;
      w2_0 <= w1_0;
      w2_1 <= w1_1;
      w2_2 <= w1_2;
    end
  end

  // Larger / smaller of the two absolute gradients for the max-min approximation
  always_comb begin
    mx = ax;
    mn = ay;
    if (ay > ax) begin
      mx = ay;
      mn = ax;
    end
  end

  // S2 partial sums, S3 absolute differences, S4 magnitude
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_p <= '0;
      gx_n <= '0;
      gy_p <= '0;
      gy_n <= '0;
      ax   <= '0;
      ay   <= '0;
      m    <= '0;
    end else begin
      gx_p <= SW'(row0) + SW'({row1, 1'b0}) + SW'(y1);
      gx_n <= SW'(w2_0) + SW'({w2_1, 1'b0}) + SW'(w2_2);
      gy_p <= SW'(w2_0) + SW'({w1_0, 1'b0}) + SW'(row0);
      gy_n <= SW'(w2_2) + SW'({w1_2, 1'b0}) + SW'(y1);
      ax   <= (gx_p >= gx_n) ? (gx_p - gx_n) : (gx_n - gx_p);
      ay   <= (gy_p >= gy_n) ? (gy_p - gy_n) : (gy_n - gy_p);
      if (mag_mode_f == MAG_MAXMIN) m <= MW'(mx) + MW'(mn >> 1);
      else                          m <= MW'(ax) + MW'(ay);
    end
  end

  // Sync and border flags travel alongside the data through stages S1..S4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LAT - 1; i++) begin
        sync_q[i] <= '0;
        bg_q[i]   <= 1'b0;
      end
    end else begin
      sync_q[0] <= '{vs: vid.in_vs, hs: vid.in_hs, de: vid.in_de};
      bg_q[0]   <= border;
      for (int unsigned i = 1; i < LAT - 1; i++) begin
        sync_q[i] <= sync_q[i-1];
        bg_q[i]   <= bg_q[i-1];
      end
    end
  end

  // S5: threshold or saturate, background on borders, zero outside active video
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.out_vs   <= 1'b0;
      vid.out_hs   <= 1'b0;
      vid.out_de   <= 1'b0;
      vid.out_data <= '0;
    end else begin
      vid.out_vs <= sync_q[LAST].vs;
      vid.out_hs <= sync_q[LAST].hs;
      vid.out_de <= sync_q[LAST].de;
      if (!sync_q[LAST].de) begin
        vid.out_data <= '0;
      end else if (out_sel_f == OUT_BIN) begin
        vid.out_data <= (!bg_q[LAST] && (m >= threshold_f)) ? '0 : '1;
      end else if (bg_q[LAST]) begin
        vid.out_data <= '0;
      end else begin
        vid.out_data <= (m > SAT) ? '1 : DATA_W'(m);
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_param.sv
// Randomised frame-level bench for sobel_edge_param against a whole-image Sobel model.
module tb_sobel_edge_param;
  import sobel_pkg::*;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 8;
  localparam int LINES  = 8;
  localparam int MAXC   = 16;
  localparam int HMAX   = 4096;
  localparam int DLY    = int'(LAT) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W+2:0] threshold;
  logic              mag_mode;
  logic              out_sel;
  logic              line_ovf;

  sobel_edge_param_if #(.DATA_W(DATA_W)) vid ();

  sobel_edge_param #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vid       (vid),
    .threshold (threshold),
    .mag_mode  (mag_mode),
    .out_sel   (out_sel),
    .line_ovf  (line_ovf)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         n      = 0;
  logic [2:0] h_sync [HMAX];
  logic [7:0] h_data [HMAX];

  // Reference model state: the frame image and the configuration latched at frame start
  int img [LINES][MAXC];
  int thr_f  = 0;
  bit mode_f = 1'b0;
  bit osel_f = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_pix(input int r, input int c);
    int gx, gy, ax, ay, hi, lo, m;
    if (r < 2 || c < 2 || c >= IMG_W) return osel_f ? 8'h00 : 8'hFF;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c])
       - (img[r][c-2] + 2*img[r][c-1] + img[r][c]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    hi = (ax > ay) ? ax : ay;
    lo = (ax > ay) ? ay : ax;
    m  = mode_f ? (hi + lo / 2) : (ax + ay);
    if (osel_f) return (m > 255) ? 8'hFF : 8'(m);
    return (m >= thr_f) ? 8'h00 : 8'hFF;
  endfunction

  task automatic fill(input int pat);
    for (int r = 0; r < LINES; r++) begin
      for (int c = 0; c < MAXC; c++) begin
        case (pat)
          0:       img[r][c] = 128;
          1:       img[r][c] = (c >= 4) ? 255 : 0;
          2:       img[r][c] = (c > r) ? 255 : 0;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  // One clock: apply inputs, then compare outputs with the inputs from LAT cycles earlier
  task automatic step(input bit vs, input bit hs, input bit de,
                      input logic [7:0] y, input logic [7:0] expd);
    vid.in_vs = vs;
    vid.in_hs = hs;
    vid.in_de = de;
    vid.in_y  = de ? y : 8'h00;
    h_sync[n] = {vs, hs, de};
    h_data[n] = de ? expd : 8'h00;
    @(posedge clk);
    #1;
    if (n >= DLY) begin
      check_val("out_vs",   32'(vid.out_vs),   32'(h_sync[n-DLY][2]));
      check_val("out_hs",   32'(vid.out_hs),   32'(h_sync[n-DLY][1]));
      check_val("out_de",   32'(vid.out_de),   32'(h_sync[n-DLY][0]));
      check_val("out_data", 32'(vid.out_data), 32'(h_data[n-DLY]));
    end
    if (n >= HMAX - 1) begin
      $display("FAIL history: step budget of %0d exhausted", HMAX);
      $fatal(1, "history overflow");
    end
    n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic check_zero_outputs();
    check_val("rst_out_vs",   32'(vid.out_vs),   32'd0);
    check_val("rst_out_hs",   32'(vid.out_hs),   32'd0);
    check_val("rst_out_de",   32'(vid.out_de),   32'd0);
    check_val("rst_out_data", 32'(vid.out_data), 32'd0);
    check_val("rst_line_ovf", 32'(line_ovf),     32'd0);
  endtask

  // Asynchronous reset between clock edges; everything in flight is discarded
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs();
    for (int k = n - DLY; k < n; k++) begin
      if (k >= 0) begin
        h_sync[k] = 3'b000;
        h_data[k] = 8'h00;
      end
    end
    thr_f  = 0;
    mode_f = 1'b0;
    osel_f = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic run_frame(input int pat, input int thr, input bit mode, input bit osel,
                           input int mid_thr, input int ovf_line, input int rst_line);
    int len;
    fill(pat);
    threshold = 11'(thr);
    mag_mode  = mode;
    out_sel   = osel;
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    thr_f  = thr;
    mode_f = mode;
    osel_f = osel;
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(2);
    check_val("ovf_clear", 32'(line_ovf), 32'd0);
    for (int r = 0; r < LINES; r++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      idle(1);
      len = (r == ovf_line) ? IMG_W + 2 : IMG_W;
      for (int c = 0; c < len; c++) begin
        if (mid_thr >= 0 && r == LINES / 2 && c == 2) threshold = 11'(mid_thr);
        step(1'b0, 1'b0, 1'b1, 8'(img[r][c]), ref_pix(r, c));
        if (r == rst_line && c == 4) begin
          mid_reset();
          return;
        end
      end
      idle(2);
    end
    idle(6);
    check_val("line_ovf", 32'(line_ovf), (ovf_line >= 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst_n     = 1'b1;
    vid.in_vs = 1'b0;
    vid.in_hs = 1'b0;
    vid.in_de = 1'b0;
    vid.in_y  = 8'h00;
    threshold = '0;
    mag_mode  = 1'b0;
    out_sel   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs();
    idle(3);
    rst_n = 1'b1;
    idle(3);

    // Flat field, both output modes
    run_frame(0, 100, 1'b0, 1'b0, -1, -1, -1);
    run_frame(0, 100, 1'b0, 1'b1, -1, -1, -1);
    // Vertical step, binary and magnitude
    run_frame(1, 200, 1'b0, 1'b0, -1, -1, -1);
    run_frame(1, 200, 1'b0, 1'b1, -1, -1, -1);
    // Diagonal step, both magnitude formulas
    run_frame(2, 900, 1'b1, 1'b0, -1, -1, -1);
    run_frame(2, 900, 1'b0, 1'b0, -1, -1, -1);
    run_frame(2, 0,   1'b1, 1'b1, -1, -1, -1);
    // Threshold changed mid-frame only takes effect on the next frame
    run_frame(1, 200,  1'b0, 1'b0, 1021, -1, -1);
    run_frame(1, 1021, 1'b0, 1'b0, -1,   -1, -1);
    // Random images and configurations
    for (int f = 0; f < 4; f++) begin
      run_frame(3, int'($urandom_range(0, 1100)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1, -1, -1);
    end
    // Over-long line, then the flag clears at the following frame
    run_frame(3, int'($urandom_range(100, 600)), 1'b0, 1'b0, -1, 3, -1);
    run_frame(3, int'($urandom_range(100, 600)), 1'b1, 1'b1, -1, -1, -1);
    // Reset in the middle of a line
    run_frame(3, 300, 1'b1, 1'b1, -1, -1, 3);
    // Lines before the first frame start after reset are background
    for (int l = 0; l < 3; l++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      idle(1);
      for (int c = 0; c < IMG_W; c++) begin
        step(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)), 8'hFF);
      end
      idle(2);
    end
    idle(3);
    run_frame(3, int'($urandom_range(100, 900)), 1'b0, 1'b0, -1, -1, -1);
    run_frame(3, int'($urandom_range(100, 900)), 1'b1, 1'b1, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
